muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Multi-cycle sequencer for the HI/LO register pair in the EX stage. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the decoder, computes 64-bit results (single-step multiply, 32-step restoring divide), stalls the pipeline while busy, and drives the single write-enable and both data inputs of the HI/LO register. Merges MTHI/MTLO with the current HI/LO value because the register has one shared write-enable.

## Interface
- WIDTH, 32, operand width; HI/LO are WIDTH each.
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- valid  in  1  EX instruction is a HI/LO-writing op
- op  in  3  NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6
- a  in  WIDTH  rs operand (dividend / multiplicand / MT source)
- b  in  WIDTH  rt operand (divisor / multiplier)
- flush  in  1  exception/branch cancel of the EX instruction
- hi_cur, lo_cur  in  WIDTH  current HI/LO register outputs
- stall  out  1  hold IF..EX
- hilo_we  out  1  HI/LO write enable
- hi_wdata, lo_wdata  out  WIDTH  HI/LO write data

## Operation
- States: IDLE, MUL, DIV, FIX, WRITE.
- IDLE, valid=1, flush=0:
  - MULT/MULTU: latch operands → MUL.
  - DIV/DIVU with b≠0: latch |a|, |b| (signed) or raw values (unsigned), latch sign flags, clear iteration counter → DIV.
  - DIV/DIVU with b=0: result hi=a, lo={WIDTH{1}} → WRITE.
  - MTHI: combinational same-cycle write, hilo_we=1, hi_wdata=a, lo_wdata=lo_cur. Stays IDLE.
  - MTLO: combinational same-cycle write, hilo_we=1, hi_wdata=hi_cur, lo_wdata=a. Stays IDLE.
  - NOP: no action.
- MUL: result = signed or unsigned 2·WIDTH product; {hi,lo}=product → WRITE.
- DIV: one restoring step per cycle (shift remainder, trial subtract, set quotient bit). After WIDTH steps → FIX.
- FIX: signed only:
  - quotient negated iff operand signs differ;
  - remainder negated iff dividend negative;
  - 0x80000000/−1 gives lo=0x80000000, hi=0 (no trap).
  - hi=remainder, lo=quotient → WRITE.
- WRITE: hilo_we=1 from registered result → IDLE. valid/op ignored this cycle (it is the completing instruction).
- flush=1 in any state: next state IDLE; hilo_we forced 0 that cycle, including MT* and WRITE; IDLE accept suppressed.
- Outputs when not writing: hilo_we=0, hi_wdata=lo_wdata=0.

## Timing
- Reset (rstn low, async): state IDLE, stall=0, hilo_we=0, hi_wdata=lo_wdata=0, internal result/counter cleared. Reset mid-operation discards the op without writing.
- stall: combinational.
  - 1 in IDLE when a MULT/MULTU/DIV/DIVU is accepted.
  - 1 in MUL, DIV, FIX.
  - 0 in WRITE, so the instruction leaves EX on the same edge HI/LO is written.
  - flush forces stall=0.
- Cycle numbering from accept cycle = 0:
  - MTHI/MTLO: write in cycle 0, no stall.
  - MULT/MULTU: stall cycles 0–1, write cycle 2.
  - DIV/DIVU: stall cycles 0–33, DIV cycles 1–32, FIX cycle 33, write cycle 34. DIVU also passes through FIX (no-op) for fixed latency.
  - Divide by zero: stall cycle 0, write cycle 1.
- Back-to-back: the op in EX the cycle after WRITE is accepted normally.

## Structure
- Shared defines header: op encodings, state encodings, WIDTH default.
- Sub-module div_radix2_step: combinational single restoring iteration (remainder, quotient, divisor in; next remainder/quotient out). Controller owns counter and registers.
- Product via a single multiplier expression; sign-extend operands to 2·WIDTH for MULT.

## Test plan
- Reset: hold rstn low with valid=1, op=DIV → stall=0, hilo_we=0, data 0. Release → IDLE, no write.
- MULT a=0xFFFFFFFE, b=3 → cycle 2 hilo_we=1, hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU same operands → hi=0x00000002, lo=0xFFFFFFFA; stall high cycles 0–1 only.
- DIV a=0xFFFFFFF9 (−7), b=2 → cycle 34 hi=0xFFFFFFFF, lo=0xFFFFFFFD; DIVU a=100, b=7 → hi=2, lo=14; stall high exactly cycles 0–33.
- DIV a=5, b=0 → cycle 1 hi=5, lo=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF → hi=0, lo=0x80000000.
- MTHI a=0x12345678, lo_cur=0xAAAA5555 → same cycle hilo_we=1, hi=0x12345678, lo=0xAAAA5555, stall=0. MTLO mirrors with hi_cur.
- Flush at DIV cycle 10 → no hilo_we ever, stall 0 that cycle, IDLE next; MULT issued next cycle completes normally. rstn pulse at MUL → no write, IDLE.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
package muldiv_ctrl_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_WRITE
    } state_t;

endpackage

// File: rtl/div_radix2_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial subtract.
module div_radix2_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] div,
    output logic [WIDTH-1:0] rem_n,
    output logic [WIDTH-1:0] quo_n
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, div};
        if (diff[WIDTH]) begin
            rem_n = shifted[WIDTH-1:0];
            quo_n = {quo[WIDTH-2:0], 1'b0};
        end else begin
            rem_n = diff[WIDTH-1:0];
            quo_n = {quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer: multiply, 32-step restoring divide, MTHI/MTLO merge, pipeline stall.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic [WIDTH-1:0] hi_cur,
    input  logic [WIDTH-1:0] lo_cur,
    output logic             stall,
    output logic             hilo_we,
    output logic [WIDTH-1:0] hi_wdata,
    output logic [WIDTH-1:0] lo_wdata
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state, state_n;
    logic [WIDTH-1:0] opa, opb, rem;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic [CW-1:0]    cnt;
    logic             sgn, neg_q, neg_r;
    logic             accept;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod;
    logic [WIDTH-1:0] rem_n, quo_n;

    assign accept = rstn && valid && !flush && (state == S_IDLE);

    always_comb begin
        ext_a = sgn ? {{WIDTH{opa[WIDTH-1]}}, opa} : {{WIDTH{1'b0}}, opa};
        ext_b = sgn ? {{WIDTH{opb[WIDTH-1]}}, opb} : {{WIDTH{1'b0}}, opb};
        prod  = ext_a * ext_b;
    end

    always_comb begin
        a_mag = ((op_t'(op) == OP_DIV) && a[WIDTH-1]) ? -a : a;
        b_mag = ((op_t'(op) == OP_DIV) && b[WIDTH-1]) ? -b : b;
    end

    // During divide, opa holds the shifting quotient and opb the divisor magnitude.
    div_radix2_step #(.WIDTH(WIDTH)) u_step (
        .rem   (rem),
        .quo   (opa),
        .div   (opb),
        .rem_n (rem_n),
        .quo_n (quo_n)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        stall    = 1'b0;
        hilo_we  = 1'b0;
        hi_wdata = '0;
        lo_wdata = '0;
        unique case (state)
            S_IDLE: begin
                if (valid) begin
                    case (op_t'(op))
                        OP_MULT, OP_MULTU: begin
                            stall   = 1'b1;
                            state_n = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            stall   = 1'b1;
                            state_n = (b == '0) ? S_WRITE : S_DIV;
                        end
                        OP_MTHI: begin
                            hilo_we  = 1'b1;
                            hi_wdata = a;
                            lo_wdata = lo_cur;
                        end
                        OP_MTLO: begin
                            hilo_we  = 1'b1;
                            hi_wdata = hi_cur;
                            lo_wdata = a;
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                stall   = 1'b1;
                state_n = S_WRITE;
            end
            S_DIV: begin
                stall = 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    state_n = S_FIX;
                end
            end
            S_FIX: begin
                stall   = 1'b1;
                state_n = S_WRITE;
            end
            S_WRITE: begin
                hilo_we  = 1'b1;
                hi_wdata = res_hi;
                lo_wdata = res_lo;
                state_n  = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        // Cancel and reset override everything, including same-cycle MT writes.
        if (flush || !rstn) begin
            state_n  = S_IDLE;
            stall    = 1'b0;
            hilo_we  = 1'b0;
            hi_wdata = '0;
            lo_wdata = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            opa    <= '0;
            opb    <= '0;
            rem    <= '0;
            res_hi <= '0;
            res_lo <= '0;
            cnt    <= '0;
            sgn    <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (op_t'(op))
                            OP_MULT, OP_MULTU: begin
                                opa <= a;
                                opb <= b;
                                sgn <= (op_t'(op) == OP_MULT);
                            end
                            OP_DIV, OP_DIVU: begin
                                if (b == '0) begin
                                    res_hi <= a;
                                    res_lo <= '1;
                                end else begin
                                    opa   <= a_mag;
                                    opb   <= b_mag;
                                    rem   <= '0;
                                    cnt   <= '0;
                                    sgn   <= (op_t'(op) == OP_DIV);
                                    neg_q <= (op_t'(op) == OP_DIV) && (a[WIDTH-1] ^ b[WIDTH-1]);
                                    neg_r <= (op_t'(op) == OP_DIV) && a[WIDTH-1];
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    {res_hi, res_lo} <= prod;
                end
                S_DIV: begin
                    rem <= rem_n;
                    opa <= quo_n;
                    cnt <= cnt + CW'(1);
                end
                S_FIX: begin
                    res_hi <= neg_r ? -rem : rem;
                    res_lo <= neg_q ? -opa : opa;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: directed ops, expected writes queued, monitor checks.
module tb_muldiv_ctrl;

    localparam logic [2:0] NOP = 3'd0, MULT = 3'd1, MULTU = 3'd2, DIV = 3'd3,
                           DIVU = 3'd4, MTHI = 3'd5, MTLO = 3'd6;

    logic        clk = 1'b0;
    logic        rstn, valid, flush, stall, hilo_we;
    logic [2:0]  op;
    logic [31:0] a, b, hi_cur, lo_cur, hi_wdata, lo_wdata;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   ntests = 0;
    int   nfail = 0;

    muldiv_ctrl #(.WIDTH(32)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .valid    (valid),
        .op       (op),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .hi_cur   (hi_cur),
        .lo_cur   (lo_cur),
        .stall    (stall),
        .hilo_we  (hilo_we),
        .hi_wdata (hi_wdata),
        .lo_wdata (lo_wdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every write must match the oldest queued expectation, including its cycle.
    always @(negedge clk) begin
        if (rstn) begin
            if (hilo_we) begin
                if (sbq.size() == 0) begin
                    ntests++;
                    nfail++;
                    $display("FAIL unexpected_write at cycle %0d: got hi=%h lo=%h, expected no write",
                             cyc, hi_wdata, lo_wdata);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("write_hi", 64'(hi_wdata), 64'(e.hi));
                    chk("write_lo", 64'(lo_wdata), 64'(e.lo));
                    chk("write_cycle", 64'(cyc), 64'(e.cyc));
                end
            end else begin
                chk("idle_data_zero", {hi_wdata, lo_wdata}, 64'd0);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after the write.
    task automatic run_op(input logic [2:0] o, input logic [31:0] ia, input logic [31:0] ib,
                          input logic [31:0] eh, input logic [31:0] el,
                          input int lat, input int nst, input string nm);
        valid = 1'b1;
        op    = o;
        a     = ia;
        b     = ib;
        sbq.push_back('{eh, el, cyc + lat});
        for (int i = 0; i <= lat; i++) begin
            @(negedge clk);
            chk({nm, "_stall"}, 64'(stall), 64'(i < nst));
            @(posedge clk);
            #1;
            if (i == 0) valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rstn   = 1'b0;
        valid  = 1'b1;
        op     = DIV;
        a      = 32'd5;
        b      = 32'd3;
        flush  = 1'b0;
        hi_cur = 32'h5555AAAA;
        lo_cur = 32'hAAAA5555;

        @(negedge clk);
        chk("reset_stall", 64'(stall), 64'd0);
        chk("reset_we", 64'(hilo_we), 64'd0);
        chk("reset_data", {hi_wdata, lo_wdata}, 64'd0);
        @(posedge clk);
        #1;
        valid = 1'b0;
        op    = NOP;
        rstn  = 1'b1;
        @(negedge clk);
        chk("post_reset_stall", 64'(stall), 64'd0);
        chk("post_reset_we", 64'(hilo_we), 64'd0);
        @(posedge clk);
        #1;

        run_op(MULT,  32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 2, 2, "mult");
        run_op(MULTU, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 2, 2, "multu");
        run_op(DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 34, 34, "div_neg");
        run_op(DIVU,  32'd100, 32'd7, 32'd2, 32'd14, 34, 34, "divu");
        run_op(DIV,   32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 34, 34, "div_negdivisor");
        run_op(DIV,   32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1, 1, "div_by_zero");
        run_op(DIVU,  32'hDEADBEEF, 32'd0, 32'hDEADBEEF, 32'hFFFFFFFF, 1, 1, "divu_by_zero");
        run_op(DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 34, 34, "div_overflow");
        run_op(DIVU,  32'hFFFFFFFF, 32'd16, 32'd15, 32'h0FFFFFFF, 34, 34, "divu_max");
        run_op(MTHI,  32'h12345678, 32'd0, 32'h12345678, 32'hAAAA5555, 0, 0, "mthi");
        run_op(MTLO,  32'h87654321, 32'd0, 32'h5555AAAA, 32'h87654321, 0, 0, "mtlo");
        // back-to-back: multiply immediately after an MTLO and after another multiply
        run_op(MULT,  32'd6, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFD6, 2, 2, "mult_b2b");
        run_op(MULTU, 32'h10000, 32'h10000, 32'd1, 32'd0, 2, 2, "multu_b2b");

        // flushed MTHI never writes
        valid = 1'b1;
        op    = MTHI;
        a     = 32'h0BADF00D;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_mthi_we", 64'(hilo_we), 64'd0);
        chk("flush_mthi_stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        valid = 1'b0;
        flush = 1'b0;

        // divide flushed in its tenth cycle, then a multiply on the very next cycle
        valid = 1'b1;
        op    = DIV;
        a     = 32'd100;
        b     = 32'd7;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("flushdiv_stall", 64'(stall), 64'd1);
            @(posedge clk);
            #1;
            if (i == 0) valid = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        chk("flush_cycle_stall", 64'(stall), 64'd0);
        chk("flush_cycle_we", 64'(hilo_we), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        run_op(MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 2, 2, "mult_after_flush");

        // asynchronous reset pulse while in MUL discards the op
        valid = 1'b1;
        op    = MULT;
        a     = 32'd9;
        b     = 32'd9;
        @(negedge clk);
        chk("rstmul_stall0", 64'(stall), 64'd1);
        @(posedge clk);
        #1;
        valid = 1'b0;
        rstn  = 1'b0;
        #2;
        chk("rstmul_stall", 64'(stall), 64'd0);
        chk("rstmul_we", 64'(hilo_we), 64'd0);
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        run_op(MTHI, 32'hCAFEBABE, 32'd0, 32'hCAFEBABE, 32'hAAAA5555, 0, 0, "mthi_after_rst");

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
